// File: rtl/multu_hilo_ctrl.sv
// Multi-cycle MULTU sequencer owning the architectural HI/LO registers.
// Shift-add unsigned multiply, one multiplier bit per cycle. The block also
// generates the EX-stage interlock and serves MFHI/MFLO reads.
module multu_hilo_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mf_req,
  input  logic             mf_sel,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hilo_rd
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0] mplier, mplier_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic             done_n;
  logic [WIDTH:0]   sum;

  // State, datapath and architectural HI/LO registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      hi     <= hi_n;
      lo     <= lo_n;
      done   <= done_n;
    end
  end

  // Next-state and datapath: accept in IDLE, one shift-add step per RUN cycle.
  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    cnt_n    = cnt;
    hi_n     = hi;
    lo_n     = lo;
    done_n   = 1'b0;
    // Carry out of the add lands in acc's MSB after the right shift.
    sum      = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);

    unique case (state)
      IDLE: begin
        if (start) begin
          mcand_n  = src_a;
          mplier_n = src_b;
          acc_n    = '0;
          cnt_n    = '0;
          state_n  = RUN;
        end
      end
      RUN: begin
        acc_n    = sum[WIDTH:1];
        mplier_n = {sum[0], mplier[WIDTH-1:1]};
        cnt_n    = CNT_W'(cnt + 1'b1);
        if (cnt == CNT_LAST) begin
          // HI/LO change only here, so partial products never leak out.
          hi_n    = sum[WIDTH:1];
          lo_n    = {sum[0], mplier[WIDTH-1:1]};
          cnt_n   = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pipeline-facing decode: busy flag, interlock and MFHI/MFLO read port.
  assign busy    = (state == RUN);
  assign stall   = busy & (start | mf_req);
  assign hilo_rd = mf_sel ? hi : lo;

endmodule

// File: tb/tb_multu_hilo_ctrl.sv
// Scoreboard bench for multu_hilo_ctrl: stimulus pushes the expected 64-bit
// product, a negedge monitor pops it whenever done pulses.
module tb_multu_hilo_ctrl;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic             mf_req;
  logic             mf_sel;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hilo_rd;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  multu_hilo_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .src_a   (src_a),
    .src_b   (src_b),
    .mf_req  (mf_req),
    .mf_sel  (mf_sel),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .hilo_rd (hilo_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding product.
  always @(negedge clk) begin : mon
    logic [63:0] p;
    if (rst === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
      else begin
        p = exp_q.pop_front();
        chk("mon_hi", 64'(hi), 64'(p[63:32]));
        chk("mon_lo", 64'(lo), 64'(p[31:0]));
      end
    end
  end

  function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic do_mult(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    int n;
    bit hold_ok;
    prod = product(a, b);
    @(negedge clk);
    start = 1'b1; src_a = a; src_b = b;
    exp_q.push_back(prod);
    #1 chk("start_idle_stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0;
    n = 0; hold_ok = 1'b1;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(n), 64'(WIDTH));
    chk("hilo_hold", 64'(hold_ok), 64'd1);
    chk("done_pulse", 64'(done), 64'd1);
    m_hi = prod[63:32];
    m_lo = prod[31:0];
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  // mf_req is presented after edge E0+k, so it overlaps WIDTH-k busy cycles.
  task automatic interlock(input logic [31:0] a, input logic [31:0] b, input int k);
    logic [63:0] prod;
    int n;
    prod = product(a, b);
    @(negedge clk);
    start = 1'b1; src_a = a; src_b = b;
    exp_q.push_back(prod);
    @(negedge clk);
    start = 1'b0;
    repeat (k) @(negedge clk);
    mf_req = 1'b1; mf_sel = 1'b1;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("mf_stall_cycles", 64'(n), 64'(WIDTH - k));
    chk("mf_release_done", 64'(done), 64'd1);
    m_hi = prod[63:32];
    m_lo = prod[31:0];
    chk("mfhi_rd", 64'(hilo_rd), 64'(m_hi));
    mf_sel = 1'b0;
    #1 chk("mflo_rd", 64'(hilo_rd), 64'(m_lo));
    mf_req = 1'b0;
  endtask

  task automatic back_to_back(input logic [31:0] a1, input logic [31:0] b1,
                              input logic [31:0] a2, input logic [31:0] b2);
    logic [63:0] p1, p2;
    int n, t0, t1;
    p1 = product(a1, b1);
    p2 = product(a2, b2);
    @(negedge clk);
    start = 1'b1; src_a = a1; src_b = b1;
    exp_q.push_back(p1);
    t0 = cyc;
    @(negedge clk);
    src_a = a2; src_b = b2;
    exp_q.push_back(p2);
    #1;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    t1 = cyc;
    chk("b2b_stall_cycles", 64'(n), 64'(WIDTH));
    chk("b2b_mid_done", 64'(done), 64'd1);
    chk("b2b_mid_lo", 64'(lo), 64'(p1[31:0]));
    chk("b2b_accept_gap", 64'(t1 - t0), 64'(WIDTH + 1));
    m_hi = p1[63:32];
    m_lo = p1[31:0];
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_busy2_cycles", 64'(n), 64'(WIDTH));
    chk("b2b_final_lo", 64'(lo), 64'(p2[31:0]));
    m_hi = p2[63:32];
    m_lo = p2[31:0];
  endtask

  task automatic reset_mid(input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    start = 1'b1; src_a = a; src_b = b;
    exp_q.push_back(product(a, b));
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    mf_req = 1'b1;
    rst = 1'b0;
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    mf_req = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) n++;
    end
    chk("rst_no_done", 64'(n), 64'd0);
  endtask

  task automatic idle_read();
    @(negedge clk);
    mf_req = 1'b1;
    mf_sel = 1'($urandom_range(0, 1));
    #1;
    chk("idle_stall", 64'(stall), 64'd0);
    chk("idle_rd", 64'(hilo_rd), 64'(mf_sel ? m_hi : m_lo));
    mf_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    start = 1'b0; mf_req = 1'b0; mf_sel = 1'b0;
    src_a = '0; src_b = '0;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    rst = 1'b1;

    do_mult(32'd3, 32'd5);
    chk("basic_hi", 64'(hi), 64'h0);
    chk("basic_lo", 64'(lo), 64'hF);
    idle_read();
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("max_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("max_lo", 64'(lo), 64'h1);
    interlock(32'h0001_0000, 32'h0001_0000, 1);
    for (int i = 0; i < 3; i++)
      interlock($urandom, $urandom, int'($urandom_range(1, WIDTH - 1)));
    back_to_back(32'd7, 32'd6, 32'd2, 32'd9);
    for (int i = 0; i < 4; i++) begin
      do_mult($urandom, $urandom);
      idle_read();
    end
    reset_mid(32'd100, 32'd100);
    do_mult(32'd0, 32'hDEAD_BEEF);
    chk("zero_hi", 64'(hi), 64'h0);
    chk("zero_lo", 64'(lo), 64'h0);
    idle_read();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multu_hilo_ctrl.md
# multu_hilo_ctrl

Multi-cycle controller for the MULTU/MFHI/MFLO path of the `mips_pipeline` CPU. It owns the architectural HI/LO registers and sequences an iterative shift-add unsigned multiply when the EX stage presents MULTU. It drives a stall into the pipeline whenever EX holds an instruction that needs the unit while a multiply is in flight. MFHI/MFLO read through this block instead of directly from the register file.

## Interface

- `WIDTH`, 32, operand width; HI and LO are each WIDTH bits; product is 2*WIDTH.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: EX holds MULTU (opcode 0, funct 25).
- `src_a` in WIDTH: rs operand (multiplicand).
- `src_b` in WIDTH: rt operand (multiplier).
- `mf_req` in 1: EX holds MFHI/MFLO (funct 16/18).
- `mf_sel` in 1: 1 selects HI (MFHI), 0 selects LO (MFLO).
- `stall` out 1: freeze PC, IF/ID and ID/EX; insert bubble into EX/MEM.
- `busy` out 1: multiply in progress.
- `done` out 1: one-cycle pulse on the cycle after the final iteration.
- `hi` out WIDTH: architectural HI.
- `lo` out WIDTH: architectural LO.
- `hilo_rd` out WIDTH: `mf_sel ? hi : lo`, combinational, routed to the write-back mux.

## Operation

- FSM with two states, IDLE and RUN. `busy` = (state == RUN).
- **Accept:** IDLE and `start` -> load `mcand`=src_a, `mplier`=src_b, `acc`=0, `cnt`=0, go to RUN.
- **RUN iteration:**
  - `sum` = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : 0), computed WIDTH+1 bits wide.
  - {acc, mplier} <= {sum, mplier} >> 1; the carry from `sum` becomes acc's MSB.
  - `cnt`++.
- **Completion:** in RUN with `cnt` == WIDTH-1, the edge writes `hi`=new acc and `lo`=new mplier, returns to IDLE, and sets `done` for one cycle.
- `hi`/`lo` keep their previous values for the whole RUN phase. Partial products are never visible.
- `stall` = busy & (start | mf_req). This is combinational, from state and inputs.
- While `stall` is high, the pipeline holds EX, so `start`/`mf_req` and operands stay stable. The block ignores `start` during RUN; it does not queue it.
- `start` and `mf_req` are mutually exclusive in a single-issue EX. If both are high, `start` wins and `mf_req` is don't-care.
- Overflow is impossible: the product always fits in 2*WIDTH bits. Signed operands are treated as unsigned.

## Timing

- **Reset (async, rst=0):**
  - state=IDLE, busy=0, done=0, stall=0, cnt=0.
  - hi=lo=0, acc=mcand=mplier=0.
- **Reset mid-RUN:** aborts the multiply. HI/LO read 0 and no `done` pulse follows.
- **Latency:**
  - `start` sampled at edge E0.
  - Result is in `hi`/`lo` after edge E0+WIDTH.
  - `busy` is high for exactly WIDTH cycles.
  - `done` is high in the cycle after E0+WIDTH.
- **MULTU at idle:** never stalls.
- **MFHI/MFLO issued k cycles after start (1 ≤ k < WIDTH):**
  - `stall` is high for WIDTH-k cycles.
  - Release happens in the `done` cycle, where `hilo_rd` already shows the new value.
- **Back-to-back MULTU:**
  - The second `start` stalls until the `done` cycle.
  - It is accepted on that edge, giving WIDTH+1 cycles between accepts when issued the cycle after the first.
- **MFHI/MFLO with unit idle:** `hilo_rd` is valid in the same cycle, with zero stall.

## Test plan

- **Basic multiply:** reset, then start with src_a=3, src_b=5.
  - busy high for 32 cycles.
  - done pulses once.
  - hi=0x00000000, lo=0x0000000F.
- **Maximum operands:** src_a=src_b=0xFFFFFFFF.
  - hi=0xFFFFFFFE, lo=0x00000001 after 32 cycles.
  - Prior hi/lo are unchanged while busy.
- **Interlock on MFHI:** start with 0x00010000 × 0x00010000, then one cycle later mf_req=1, mf_sel=1.
  - stall high for 31 cycles, then low.
  - hilo_rd=0x00000001 in the release cycle.
  - MFLO there gives 0x00000000.
- **Back-to-back MULTU:** 7×6, then immediately 2×9.
  - Second start stalls until done.
  - Final lo=18, with lo=42 visible in between.
  - Accept edges are 33 cycles apart.
- **Reset mid-operation:** assert rst=0 at cycle 10 of RUN of 100×100.
  - Immediately busy=0, stall=0, hi=lo=0.
  - No done pulse.
- **Zero and idle read:** 0 × 0xDEADBEEF gives hi=lo=0. Then mf_req with the unit idle gives stall=0 and hilo_rd=0 in the same cycle.
